mix_column_seq: RTL
===================

// Module: mix_column_seq
// PURPOSE
//  Forward AES MixColumns engine for the encrypt datapath; the counterpart of the
//  existing inverse-MixColumns logic used on the decrypt path. Accepts one 128-bit
//  state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
//  Holds the result until the downstream round stage accepts it.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns computed per clock; legal values 1, 2 and 4.
//                     NSTEP = 4/COLS_PER_CYCLE.
// PORTS
//  clk        in   1    clock; all state changes on the rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    in_data is valid
//  in_ready   out  1    block can accept a state
//  in_data    in   128  input state
//  out_valid  out  1    out_data holds a completed result
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  MixColumns(in_data)
//  busy       out  1    high in BUSY state
// BEHAVIOUR
//  - Byte map, same for in and out: row r, column c = data[127-8*(4*r+c) -: 8].
//  - Output equation: out[r][c] = XOR over k of M[r][k]*s[k][c] in GF(2^8), with
//    poly 0x11b. M rows: {02,03,01,01} {01,02,03,01} {01,01,02,03} {03,01,01,02}.
//  - GF multiply: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00);
//    3*b = xtime(b) ^ b. No generic multiplier is required.
//  - States:
//    IDLE: in_ready=1.
//      On in_valid&&in_ready: capture in_data into the state register,
//      set col_cnt=0, go to BUSY.
//    BUSY: in_ready=0. Each clock writes columns col_cnt .. col_cnt+COLS_PER_CYCLE-1
//      of the result register and adds COLS_PER_CYCLE to col_cnt.
//      After the last columns are written, go to DONE.
//    DONE: out_valid=1. On out_valid&&out_ready, go to IDLE.
//  - Latency: acceptance at edge t gives out_valid high after edge t+NSTEP.
//    Example: COLS_PER_CYCLE=1 means 4 clocks. Throughput is 1 state per NSTEP+2 clocks.
//  - in_ready is high only in IDLE. No new state is accepted in BUSY or DONE, even
//    when out_ready is high in DONE.
//  - in_data changing after acceptance has no effect; the captured copy is used.
//  - out_data must not change while out_valid is high and out_ready is low.
//    out_data keeps its last result after the handshake, until the next result overwrites it.
//  - out_valid may be high with out_ready held low for any number of cycles, with no
//    loss or corruption of the result.
//  - col_cnt is 2 bits and never wraps inside a block; its value is 0 in IDLE and DONE.
//  - Reset (asynchronous, at any time including mid-BUSY or in DONE):
//    state=IDLE, col_cnt=0, in_ready=1, out_valid=0, busy=0, out_data=128'h0,
//    state register cleared. A partially processed block is dropped.
//  - An illegal COLS_PER_CYCLE value is a fatal error at elaboration.
// TESTING
//  1. FIPS-197 columns, COLS_PER_CYCLE=1:
//     in=128'hdbf201c6_130a01c6_532201c6_455c01c6
//     -> out=128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6; out_valid rises exactly 4 clocks
//     after acceptance.
//  2. in=128'hd42d_d42d... columns {d4,d4,d4,d5} and {2d,26,31,4c}
//     -> {d5,d5,d7,d6} and {4d,7e,bd,f8}; repeat for COLS_PER_CYCLE=2 and 4 with
//     latency 2 and 1.
//  3. Backpressure: out_ready=0 for 10 cycles in DONE
//     -> out_data stable, out_valid=1, in_ready=0.
//     Then out_ready=1 -> IDLE next clock, and a new in_valid is accepted.
//  4. Reset: assert rst_n=0 asynchronously in the second BUSY cycle
//     -> all outputs go to reset values immediately.
//     After release, process case 1 correctly.
//  5. Randomized: 1000 random states, random in_valid/out_ready gaps, compared against
//     a software model of MixColumns. Also check InvMixColumns(out)==in. No drops and
//     no duplicates.
//  6. Identity: in=128'h0 -> out=0; in with all bytes 8'h01 -> all bytes 8'h01.

Source files
------------

// File: rtl/mix_column_seq.sv
// mix_column_seq: forward AES MixColumns over a valid/ready handshake,
// computing COLS_PER_CYCLE columns of the captured state per clock.
module mix_column_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $fatal(1, "mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [1:0]                         r_col_cnt;
    logic [127:0]                       r_in;
    logic [127:0]                       r_out;
    logic [COLS_PER_CYCLE-1:0][1:0]     w_idx;
    logic [COLS_PER_CYCLE-1:0][31:0]    w_col_in;
    logic [COLS_PER_CYCLE-1:0][31:0]    w_col_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column packed as {row0, row1, row2, row3}
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    always_comb begin
        w_idx     = '0;
        w_col_in  = '0;
        w_col_out = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_idx[j] = r_col_cnt + 2'(j);
            for (int r = 0; r < 4; r++)
                w_col_in[j][31-8*r -: 8] = r_in[127-8*(4*r+int'(w_idx[j])) -: 8];
            w_col_out[j] = mix_col(w_col_in[j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = BUSY;
            BUSY:    if (r_col_cnt == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= 2'd0;
            r_in      <= '0;
            r_out     <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_in      <= in_data;
            r_col_cnt <= 2'd0;
        end else if (r_state == BUSY) begin
            // The 2-bit counter returns to 0 exactly on the last step
            r_col_cnt <= r_col_cnt + STEP;
            for (int j = 0; j < COLS_PER_CYCLE; j++)
                for (int r = 0; r < 4; r++)
                    r_out[127-8*(4*r+int'(w_idx[j])) -: 8] <= w_col_out[j][31-8*r -: 8];
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY);
    assign out_data  = r_out;

endmodule
